// File: rtl/fifo_cdc_pkg.sv
// Shared types and Gray-code helpers for the FIFO clock-domain-crossing blocks.
package fifo_cdc_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } wr_state_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic bit soft_reset_enabled(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction

endpackage

// File: rtl/fifo_wr_ptr_gen.sv
// Write-side binary/Gray pointer registers and registered full detection.
module fifo_wr_ptr_gen
  import fifo_cdc_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     h_rst,
  input  logic                     clear,
  input  logic                     inc,
  input  logic [ADDRESS_WIDTH:0]   rd_ptr_sync,
  output logic [ADDRESS_WIDTH-1:0] waddr,
  output logic [ADDRESS_WIDTH:0]   bin_next,
  output logic [ADDRESS_WIDTH:0]   wr_ptr_gray,
  output logic                     wr_full
);

  localparam int PW = ADDRESS_WIDTH + 1;

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] full_gray;
  logic          full_q, full_d;

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  always_comb begin
    bin_d     = clear ? '0 : bin_q + {{ADDRESS_WIDTH{1'b0}}, inc};
    gray_d    = PW'(bin2gray(32'(bin_d)));
    full_gray = {~rd_ptr_sync[PW-1:PW-2], rd_ptr_sync[PW-3:0]};
    full_d    = !clear && (gray_d == full_gray);
  end

  always_ff @(posedge clk or posedge h_rst) begin
    if (h_rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      full_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      full_q <= full_d;
    end
  end

  assign waddr       = bin_q[ADDRESS_WIDTH-1:0];
  assign bin_next    = bin_d;
  assign wr_ptr_gray = gray_q;
  assign wr_full     = full_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// FIFO write-side controller: INIT/RUN/FLUSH sequencing, fill level and almost-full.
// Optional overflow status outputs are enabled with `define FIFO_WR_OVF_STATUS_EN.
module fifo_wr_ctrl
  import fifo_cdc_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int SYNC_STAGE    = 2,
  parameter int SOFT_RESET    = 0,
  parameter int AF_THRESH     = 2**ADDRESS_WIDTH - 2
) (
  input  logic                     clk,
  input  logic                     h_rst,
  input  logic                     s_rst,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH:0]   rd_ptr_sync,
  output logic                     wr_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_waddr,
  output logic [ADDRESS_WIDTH:0]   wr_ptr_gray,
  output logic                     wr_full,
  output logic                     wr_almost_full,
  output logic [ADDRESS_WIDTH:0]   wr_level
`ifdef FIFO_WR_OVF_STATUS_EN
  ,
  output logic                     wr_ovf,
  output logic [7:0]               wr_ovf_cnt
`endif
);

  localparam int         PW        = ADDRESS_WIDTH + 1;
  localparam bit         SR_EN     = soft_reset_enabled(SOFT_RESET);
  localparam logic [1:0] INIT_LAST = 2'(SYNC_STAGE);
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

  wr_state_e     state_q, state_d;
  logic [1:0]    init_cnt_q, init_cnt_d;
  logic [PW-1:0] level_q, level_d;
  logic          af_q, af_d;
  logic          flush;
  logic          accept;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] rd_bin;

  assign flush  = (state_q == ST_FLUSH);
  assign accept = wr_en && (state_q == ST_RUN) && !wr_full;

  // INIT holds off the producer long enough for the read pointer synchronizer to settle.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 2'd1;
        end
      end
      ST_RUN: begin
        if (SR_EN && s_rst) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge h_rst) begin
    if (h_rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  fifo_wr_ptr_gen #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_ptr_gen (
    .clk         (clk),
    .h_rst       (h_rst),
    .clear       (flush),
    .inc         (accept),
    .rd_ptr_sync (rd_ptr_sync),
    .waddr       (mem_waddr),
    .bin_next    (bin_next),
    .wr_ptr_gray (wr_ptr_gray),
    .wr_full     (wr_full)
  );

  // Level uses the post-write pointer so a write and a read on one edge both land.
  always_comb begin
    rd_bin  = PW'(gray2bin(32'(rd_ptr_sync)));
    level_d = flush ? '0 : (bin_next - rd_bin);
    af_d    = !flush && (level_d >= AF_LVL);
  end

  always_ff @(posedge clk or posedge h_rst) begin
    if (h_rst) begin
      level_q <= '0;
      af_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      af_q    <= af_d;
    end
  end

  assign mem_we         = accept;
  assign wr_ready       = (state_q == ST_RUN) && !wr_full;
  assign wr_level       = level_q;
  assign wr_almost_full = af_q;

`ifdef FIFO_WR_OVF_STATUS_EN
  logic       ovf_q, ovf_d;
  logic [7:0] ovf_cnt_q, ovf_cnt_d;
  logic       ovf_hit;

  // Every refused write in RUN counts; the counter saturates rather than wrapping.
  always_comb begin
    ovf_hit   = wr_en && wr_full && (state_q == ST_RUN);
    ovf_d     = ovf_q | ovf_hit;
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_hit && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
    if (flush) begin
      ovf_d     = 1'b0;
      ovf_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge h_rst) begin
    if (h_rst) begin
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign wr_ovf     = ovf_q;
  assign wr_ovf_cnt = ovf_cnt_q;
`endif

endmodule
